// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded RV32I instruction fields into 32-bit words
// and writes them to instruction memory at consecutive word addresses.
// A single registered output stage with backpressure feeds the IMEM write port.
// The load-session FSM runs IDLE -> LOAD -> DRAIN -> DONE.
// Optional macro IMM_RANGE_CHECK_EN also flags immediates that do not fit their format.
module instr_encoder_loader #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_last,
  input  logic [2:0]                 s_fmt,
  input  logic [6:0]                 s_opcode,
  input  logic [4:0]                 s_rd,
  input  logic [4:0]                 s_rs1,
  input  logic [4:0]                 s_rs2,
  input  logic [2:0]                 s_funct3,
  input  logic [6:0]                 s_funct7,
  input  logic [31:0]                s_imm,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [31:0]                m_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_m_valid;
  logic [ADDR_W-1:0] r_m_addr;
  logic [31:0]       r_m_data;
  logic [ADDR_W-1:0] r_next_addr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_accepted;
  logic              r_done;
  logic              r_err;
  logic              w_s_ready;
  logic              w_accept;
  logic              w_at_limit;
  logic              w_word_err;

  // Pack the fields of one beat; illegal formats become a NOP.
  function automatic logic [31:0] encode_word(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    case (fmt)
      3'd0:    w = {f7, rs2, rs1, f3, rd, op};
      3'd1:    w = {imm[11:0], rs1, f3, rd, op};
      3'd2:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3'd3:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      3'd4:    w = {imm[31:12], rd, op};
      3'd5:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  // Error for one beat: illegal format, odd branch/jump offset, optional range violation.
  function automatic logic beat_error(input logic [2:0] fmt, input logic [31:0] imm);
    logic e;
    case (fmt)
      3'd3, 3'd5: e = imm[0];
      3'd6, 3'd7: e = 1'b1;
      default:    e = 1'b0;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    case (fmt)
      3'd1, 3'd2: e = e | (imm[31:11] != {21{imm[11]}});
      3'd3:       e = e | (imm[31:12] != {20{imm[12]}});
      3'd4:       e = e | (imm[11:0] != 12'd0);
      3'd5:       e = e | (imm[31:20] != {12{imm[20]}});
      default:    e = e;
    endcase
`endif
    return e;
  endfunction

  // s_ready is combinational so an accept and a drain can share one cycle.
  assign w_s_ready  = (r_state == ST_LOAD) && (!r_m_valid || m_ready);
  assign w_accept   = s_valid && w_s_ready;
  assign w_at_limit = (r_accepted == CW'(DEPTH - 1));
  assign w_word_err = beat_error(s_fmt, s_imm);

  // Session state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for the load session.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_LOAD;
        else       w_state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_accept && (s_last || w_at_limit)) w_state_nxt = ST_DRAIN;
        else                                    w_state_nxt = ST_LOAD;
      end
      ST_DRAIN: begin
        if (!r_m_valid || m_ready) w_state_nxt = ST_DONE;
        else                       w_state_nxt = ST_DRAIN;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output stage, address generation, counters and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid   <= 1'b0;
      r_m_addr    <= '0;
      r_m_data    <= 32'h0000_0000;
      r_next_addr <= '0;
      r_count     <= '0;
      r_accepted  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == ST_DONE);
      if ((r_state == ST_IDLE) && start) begin
        r_next_addr <= {base_addr[ADDR_W-1:2], 2'b00};
        r_count     <= '0;
        r_accepted  <= '0;
        r_err       <= 1'b0;
      end else begin
        if (w_accept) begin
          r_m_data    <= encode_word(s_fmt, s_opcode, s_rd, s_rs1, s_rs2,
                                     s_funct3, s_funct7, s_imm);
          r_m_addr    <= r_next_addr;
          r_next_addr <= r_next_addr + ADDR_W'(4);
          r_accepted  <= r_accepted + CW'(1);
          if (w_word_err || (w_at_limit && !s_last)) r_err <= 1'b1;
        end
        if (r_m_valid && m_ready) r_count <= r_count + CW'(1);
      end
      if (w_accept)     r_m_valid <= 1'b1;
      else if (m_ready) r_m_valid <= 1'b0;
    end
  end

  assign s_ready = w_s_ready;
  assign m_valid = r_m_valid;
  assign m_addr  = r_m_addr;
  assign m_data  = r_m_data;
  assign count   = r_count;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed vectors plus randomized
// sessions compared against a field-level encoding model and a write scoreboard.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              s_last = 1'b0;
  logic [2:0]        s_fmt = 3'd0;
  logic [6:0]        s_opcode = 7'd0;
  logic [4:0]        s_rd = 5'd0, s_rs1 = 5'd0, s_rs2 = 5'd0;
  logic [2:0]        s_funct3 = 3'd0;
  logic [6:0]        s_funct7 = 7'd0;
  logic [31:0]       s_imm = 32'd0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_data;
  logic [CW-1:0]     count;
  logic              done;
  logic              err;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_fmt(s_fmt),
    .s_opcode(s_opcode), .s_rd(s_rd), .s_rs1(s_rs1), .s_rs2(s_rs2),
    .s_funct3(s_funct3), .s_funct7(s_funct7), .s_imm(s_imm),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    bit          last;
    bit          has_fixed;
    logic [31:0] fixed;
  } beat_t;

  beat_t       beats[$];
  logic [63:0] q_exp[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else             n_pass++;
  endtask

  // Reference encoding built from bit positions with shifts and masks.
  function automatic logic [31:0] model_word(input beat_t b, output bit e);
    logic [31:0] im;
    logic [31:0] low;
    int          simm;
    logic [31:0] w;
    im   = b.imm;
    simm = $signed(b.imm);
    low  = (32'(b.rd) << 7) | 32'(b.op);
    e    = 1'b0;
    case (b.fmt)
      3'd0: w = (32'(b.f7) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12) | low;
      3'd1: begin
        w = ((im & 32'hFFF) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12) | low;
`ifdef IMM_RANGE_CHECK_EN
        if (simm < -2048 || simm > 2047) e = 1'b1;
`endif
      end
      3'd2: begin
        w = (((im >> 5) & 32'h7F) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) |
            (32'(b.f3) << 12) | ((im & 32'h1F) << 7) | 32'(b.op);
`ifdef IMM_RANGE_CHECK_EN
        if (simm < -2048 || simm > 2047) e = 1'b1;
`endif
      end
      3'd3: begin
        w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(b.rs2) << 20) |
            (32'(b.rs1) << 15) | (32'(b.f3) << 12) | (((im >> 1) & 32'hF) << 8) |
            (((im >> 11) & 32'h1) << 7) | 32'(b.op);
        if ((im % 32'd2) != 32'd0) e = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        if (simm < -4096 || simm > 4095) e = 1'b1;
`endif
      end
      3'd4: begin
        w = (im & 32'hFFFF_F000) | low;
`ifdef IMM_RANGE_CHECK_EN
        if ((im % 32'd4096) != 32'd0) e = 1'b1;
`endif
      end
      3'd5: begin
        w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
            (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | low;
        if ((im % 32'd2) != 32'd0) e = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        if (simm < -1048576 || simm > 1048575) e = 1'b1;
`endif
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
    return w;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.fmt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    b.op  = 7'($urandom);
    b.rd  = 5'($urandom);
    b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom);
    b.f3  = 3'($urandom);
    b.f7  = 7'($urandom);
    case ($urandom_range(0, 2))
      0:       b.imm = $urandom;
      1:       b.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      default: b.imm = $urandom & 32'hFFFF_F000;
    endcase
    if ($urandom_range(0, 3) != 0) b.imm[0] = 1'b0;
    b.last      = 1'b0;
    b.has_fixed = 1'b0;
    b.fixed     = 32'd0;
    return b;
  endfunction

  task automatic add_beat(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm, input bit last,
                          input bit has_fixed, input logic [31:0] fixed);
    beat_t b;
    b.fmt = fmt; b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
    b.f3 = f3; b.f7 = f7; b.imm = imm; b.last = last;
    b.has_fixed = has_fixed; b.fixed = fixed;
    beats.push_back(b);
  endtask

  task automatic drive_beat(input beat_t b);
    s_fmt = b.fmt; s_opcode = b.op; s_rd = b.rd; s_rs1 = b.rs1; s_rs2 = b.rs2;
    s_funct3 = b.f3; s_funct7 = b.f7; s_imm = b.imm; s_last = b.last;
  endtask

  // Run one session over 'beats'. mode 0: random valid/ready and stray starts;
  // mode 1: back-to-back beats with m_ready low for cycles 1..3.
  task automatic run_session(input logic [31:0] base, input int mode);
    int          idx, cyc, exp_acc, nwr;
    bit          in_load, seen_done, exp_err, prev_stall, acc_prev, e, w_acc, w_wr;
    logic [31:0] exp_addr, word, prev_addr, prev_data;
    logic [63:0] ent;
    q_exp.delete();
    exp_acc = 0;
    for (int i = 0; i < beats.size(); i++) begin
      exp_acc++;
      if (beats[i].last || exp_acc == DEPTH) break;
    end
    @(negedge clk);
    start = 1'b1; base_addr = base; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq("start_count", 32'(count), 32'd0);
    check_eq("start_err", 32'(err), 32'd0);
    exp_addr = base & 32'hFFFF_FFFC;
    idx = 0; cyc = 0; nwr = 0; in_load = 1'b1; seen_done = 1'b0; exp_err = 1'b0;
    prev_stall = 1'b0; acc_prev = 1'b0; prev_addr = 32'd0; prev_data = 32'd0;
    while (!seen_done && cyc < 300) begin
      if (idx < beats.size()) begin
        drive_beat(beats[idx]);
        s_valid = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end else begin
        drive_beat(rand_beat());
        s_valid = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      if (mode == 1) m_ready = !(cyc >= 1 && cyc <= 3);
      else           m_ready = ($urandom_range(0, 3) != 0);
      if (mode == 0 && $urandom_range(0, 15) == 0) begin
        start = 1'b1; base_addr = $urandom;
      end else begin
        start = 1'b0;
      end
      #1;
      if (done) begin
        seen_done = 1'b1;
        check_eq("done_count", 32'(count), 32'(exp_acc));
        check_eq("done_accepted", 32'(idx), 32'(exp_acc));
        check_eq("done_err", 32'(err), 32'(exp_err));
        check_eq("done_pending", 32'(q_exp.size()), 32'd0);
        check_eq("done_mvalid", 32'(m_valid), 32'd0);
        check_eq("done_nwr", 32'(nwr), 32'(exp_acc));
      end else begin
        if (acc_prev) check_eq("latency_mvalid", 32'(m_valid), 32'd1);
        if (prev_stall) begin
          check_eq("stall_addr", m_addr, prev_addr);
          check_eq("stall_data", m_data, prev_data);
        end
        if (m_valid && !m_ready) check_eq("stall_sready", 32'(s_ready), 32'd0);
        if (in_load && !m_valid) check_eq("load_sready", 32'(s_ready), 32'd1);
        if (mode == 1 && cyc >= 4 && cyc <= 6) check_eq("tput_mvalid", 32'(m_valid), 32'd1);
        w_acc = s_valid && s_ready;
        w_wr  = m_valid && m_ready;
        if (w_wr) begin
          if (q_exp.size() == 0) begin
            check_eq("spurious_write", 32'd1, 32'd0);
          end else begin
            ent = q_exp.pop_front();
            check_eq("wr_addr", m_addr, ent[63:32]);
            check_eq("wr_data", m_data, ent[31:0]);
          end
          nwr++;
        end
        if (w_acc) begin
          check_eq("accept_in_load", 32'(in_load), 32'd1);
          if (in_load && idx < beats.size()) begin
            word = model_word(beats[idx], e);
            if (beats[idx].has_fixed) word = beats[idx].fixed;
            q_exp.push_back({exp_addr, word});
            exp_addr = exp_addr + 32'd4;
            if (e) exp_err = 1'b1;
            idx++;
            if (beats[idx-1].last || idx == DEPTH) begin
              in_load = 1'b0;
              if (!beats[idx-1].last) exp_err = 1'b1;
            end
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_addr  = m_addr;
        prev_data  = m_data;
        acc_prev   = w_acc;
      end
      @(negedge clk);
      cyc++;
    end
    if (!seen_done) check_eq("session_timeout", 32'd0, 32'd1);
    start = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    #1;
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("idle_sready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
  endtask

  initial begin
    int n;
    beat_t b;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_sready", 32'(s_ready), 32'd0);
    check_eq("rst_mvalid", 32'(m_valid), 32'd0);
    check_eq("rst_maddr", m_addr, 32'd0);
    check_eq("rst_mdata", m_data, 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single R-type word.
    beats.delete();
    add_beat(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 1'b1, 32'h0020_81B3);
    run_session(32'h0000_0100, 0);

    // R, I, B, J to consecutive addresses.
    beats.delete();
    add_beat(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 1'b1, 32'h0020_81B3);
    add_beat(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFF0_0093);
    add_beat(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0, 1'b1, 32'h0020_8463);
    add_beat(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b1, 1'b1, 32'h0010_00EF);
    run_session(32'h0000_0101, 0);

    // Back-to-back beats with a 3-cycle stall after the first.
    beats.delete();
    for (int i = 0; i < 3; i++) begin
      b = rand_beat();
      b.last = (i == 2);
      beats.push_back(b);
    end
    run_session(32'h0000_2000, 1);

    // Five beats without s_last: depth limit stops at four.
    beats.delete();
    for (int i = 0; i < 5; i++) beats.push_back(rand_beat());
    run_session(32'hFFFF_FFF8, 0);

    // Illegal format and odd branch offset.
    beats.delete();
    add_beat(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd1, 7'd5, 32'd7, 1'b0, 1'b1, 32'h0000_0013);
    add_beat(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b1, 1'b0, 32'd0);
    run_session(32'h0000_0400, 0);

    // I-type immediate out of 12-bit range.
    beats.delete();
    add_beat(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 1'b0, 32'd0);
    run_session(32'h0000_0500, 0);

    // Reset while a word is stalled.
    @(negedge clk);
    start = 1'b1; base_addr = 32'h0000_0200;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_fmt = 3'd7; s_last = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check_eq("pre_rst_mvalid", 32'(m_valid), 32'd1);
    check_eq("pre_rst_err", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_mvalid", 32'(m_valid), 32'd0);
    check_eq("mid_rst_sready", 32'(s_ready), 32'd0);
    check_eq("mid_rst_count", 32'(count), 32'd0);
    check_eq("mid_rst_err", 32'(err), 32'd0);
    check_eq("mid_rst_mdata", m_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beats.delete();
    b = rand_beat();
    b.last = 1'b1;
    beats.push_back(b);
    run_session(32'h0000_0300, 0);

    // Random sessions.
    for (int s = 0; s < 30; s++) begin
      beats.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        b = rand_beat();
        if (i == n - 1) b.last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
        beats.push_back(b);
      end
      run_session($urandom, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: takes decoded instruction fields (format, opcode, registers, functs, immediate) on a valid/ready stream and packs them into RV32I 32-bit words.
- Writes each word to instruction memory at consecutive word addresses.
- Used by the bench/boot path to build test programs in IMEM without a hex file.
- One registered output stage with backpressure, plus a load-session state machine.

Parameters:
- ADDR_W, 32, width of the IMEM byte address.
- DEPTH, 1024, maximum words per session; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a session. Ignored unless in IDLE.
- base_addr  in  ADDR_W  first byte address. Sampled on start; bits [1:0] are forced to 0.
- s_valid  in  1  field beat valid.
- s_ready  out  1  field beat accepted when s_valid&&s_ready.
- s_last  in  1  marks the final beat of the session.
- s_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6 and 7 are illegal.
- s_opcode  in  7  opcode[6:0].
- s_rd, s_rs1, s_rs2  in  5 each  register indices.
- s_funct3  in  3.
- s_funct7  in  7.
- s_imm  in  32  signed immediate, byte offset for B/J, full value for U.
- m_valid  out  1  IMEM write request.
- m_ready  in  1  IMEM accepts the write.
- m_addr  out  ADDR_W  byte address.
- m_data  out  32  encoded instruction.
- count  out  $clog2(DEPTH+1)  words written this session.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky error flag; cleared on start.

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_addr=0, m_data=0, count=0, done=0, err=0. State is IDLE.
- States:
  - IDLE: start -> LOAD. On that edge, latch base_addr, clear count and err.
  - LOAD: s_ready = !m_valid || m_ready. Accepting a beat registers the word into m_data/m_addr and sets m_valid. Latency from accept to m_valid is 1 cycle.
    - An accepted beat with s_last=1 -> DRAIN.
    - An accepted beat that brings the total accepted to DEPTH -> DRAIN. If that beat has s_last=0, set err.
  - DRAIN: s_ready=0. Wait until m_valid&&m_ready, or until m_valid is already 0. Then -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Handshake rules:
  - m_valid=1 holds until m_ready; m_addr and m_data are stable while m_valid&&!m_ready.
  - Accept and drain in the same cycle is allowed, giving 1 word/cycle throughput.
  - count increments on each m_valid&&m_ready.
  - The address for word n is base + 4*n, wrapping modulo 2^ADDR_W without error.
- Encoding rules:
  - R: {f7,rs2,rs1,f3,rd,op}
  - I: {imm[11:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
  - Fields not used by a format are ignored.
- Errors (the word is still written in every case):
  - Illegal s_fmt: the word written is 0x00000013 (NOP) and err is set.
  - B or J with imm[0]=1: err is set; imm[0] is dropped.
- Other boundary conditions:
  - start while not in IDLE is ignored.
  - s_valid outside LOAD is not accepted.
  - Reset mid-session aborts immediately. Everything returns to reset values and any pending word is discarded.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: err is also set when the immediate does not fit its format. I/S: signed 12-bit. B: signed 13-bit. J: signed 21-bit. U: imm[11:0]!=0. The word is still written with the truncated immediate.
- Undefined: immediates are truncated silently; err comes only from illegal fmt and odd B/J offsets.

Test Plan:
- start, base 0x100; R op=0x33 rd=3 rs1=1 rs2=2 f3=0 f7=0, last -> m_data=0x002081B3 at m_addr=0x100; count=1; done pulses one cycle; err=0.
- I op=0x13 rd=1 rs1=0 imm=0xFFFFFFFF -> 0xFFF00093. B op=0x63 rs1=1 rs2=2 imm=8 -> 0x00208463. J op=0x6F rd=1 imm=0x800 -> 0x001000EF. These go to consecutive addresses 0x100, 0x104, 0x108.
- 3 back-to-back beats, m_ready held low 3 cycles after the first -> s_ready=0 and m_data stable while stalled; no loss or duplication; 1 word/cycle once m_ready=1.
- DEPTH=4, 5 beats offered with no s_last -> 4 words written, 5th never accepted, err=1, done pulses, count=4.
- fmt=6 -> NOP 0x00000013 written, err=1. B with imm=3 -> err=1. With IMM_RANGE_CHECK_EN, I imm=2048 -> err=1; without it, err=0.
- rst_n low while a word is stalled in LOAD -> m_valid=0, s_ready=0, count=0 immediately; a new start then works from the new base.
